// File: rtl/tag_pool_pkg.sv
// Shared types for the tag pool controller: tag width, tag type and controller states.
package tag_pool_pkg;

  localparam int POOL_DEPTH = 8;
  localparam int POOL_TW    = $clog2(POOL_DEPTH);

  typedef logic [POOL_TW-1:0] tag_t;

  typedef enum logic {
    READY  = 1'b0,
    REFILL = 1'b1
  } pool_state_e;

endpackage

// File: rtl/tag_pool_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  // Scan from farthest to nearest so the requester closest to ptr is the last writer and wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt                       = '0;
        gnt[(int'(ptr) + k) % N]  = 1'b1;
        gnt_idx                   = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/tag_pool_ctrl.sv
// Tag pool controller: circular free list of DEPTH tags shared by NREQ allocators through a
// round-robin arbiter, with one release per cycle and a DEPTH-cycle flush refill sequence.
module tag_pool_ctrl
  import tag_pool_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 8,
  localparam int TW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [TW-1:0]   gnt_tag,
  input  logic            rel_valid,
  input  logic [TW-1:0]   rel_tag,
  input  logic            flush,
  output logic            busy,
  output logic [TW:0]     free_cnt,
  output logic            empty,
  output logic            err_overflow
);

  localparam int          PW   = $clog2(NREQ);
  localparam logic [TW:0] FULL = (TW + 1)'(DEPTH);

  pool_state_e   state_q, state_d;
  logic [TW-1:0] mem_q [DEPTH];
  logic [TW-1:0] mem_d [DEPTH];
  logic [TW-1:0] head_q, head_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [TW:0]   cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] idx_q, idx_d;
  logic          err_q, err_d;

  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            grant;
  logic            rel_accept;
  logic            rel_overflow;
  logic            ready_open;

  assign ready_open   = (state_q == READY) && !flush;
  assign arb_req      = (ready_open && (cnt_q != '0)) ? req : '0;
  assign grant        = |arb_gnt;
  assign rel_accept   = ready_open && rel_valid && (cnt_q != FULL);
  assign rel_overflow = ready_open && rel_valid && (cnt_q == FULL);

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign gnt          = arb_gnt;
  assign gnt_tag      = mem_q[head_q];
  assign busy         = (state_q == REFILL);
  assign free_cnt     = cnt_q;
  assign empty        = (cnt_q == '0);
  assign err_overflow = err_q;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      READY: begin
        if (flush) begin
          state_d = REFILL;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          if (grant) begin
            head_d = head_q + 1'b1;
            ptr_d  = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          end
          if (rel_accept) begin
            mem_d[tail_q] = rel_tag;
            tail_d        = tail_q + 1'b1;
          end
          if (rel_overflow) begin
            err_d = 1'b1;
          end
          case ({rel_accept, grant})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
          endcase
        end
      end
      REFILL: begin
        // A flush during refill restarts the sweep, so busy covers DEPTH cycles after the last flush.
        if (flush) begin
          idx_d = '0;
        end else begin
          mem_d[idx_q] = idx_q;
          idx_d        = idx_q + 1'b1;
          if (idx_q == TW'(DEPTH - 1)) begin
            state_d = READY;
            head_d  = '0;
            tail_d  = '0;
            cnt_d   = FULL;
          end
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= READY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= FULL;
      ptr_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TW'(i);
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_legal:   assert property (@(posedge clk) disable iff (rst) (|gnt) |-> (!empty && !busy));
  a_cnt_bound:   assert property (@(posedge clk) disable iff (rst) cnt_q <= FULL);

endmodule

// File: tb/tb_tag_pool_ctrl.sv
// Directed self-checking bench for tag_pool_ctrl (NREQ=4, DEPTH=8).
module tb_tag_pool_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [2:0] gnt_tag;
  logic       rel_valid;
  logic [2:0] rel_tag;
  logic       flush;
  logic       busy;
  logic [3:0] free_cnt;
  logic       empty;
  logic       err_overflow;

  int checks   = 0;
  int failures = 0;

  tag_pool_ctrl #(.NREQ(4), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .gnt          (gnt),
    .gnt_tag      (gnt_tag),
    .rel_valid    (rel_valid),
    .rel_tag      (rel_tag),
    .flush        (flush),
    .busy         (busy),
    .free_cnt     (free_cnt),
    .empty        (empty),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs for the coming rising edge are sampled 2ns later.
  task automatic applyStimulus(input logic [3:0] r, input logic rv, input logic [2:0] rt,
                               input logic f);
    @(negedge clk);
    req       = r;
    rel_valid = rv;
    rel_tag   = rt;
    flush     = f;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst       = 1'b1;
    req       = '0;
    rel_valid = 1'b0;
    rel_tag   = '0;
    flush     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    rel_valid = 1'b0;
    rel_tag   = '0;
    flush     = 1'b0;
    applyReset();

    // Reset state
    applyStimulus(4'b0000, 1'b0, 3'd0, 1'b0);
    checkOutput("rst_free_cnt", 32'(free_cnt), 32'd8);
    checkOutput("rst_empty", 32'(empty), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err_overflow), 32'd0);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);

    // Single requester drains the pool in tag order
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0001, 1'b0, 3'd0, 1'b0);
      checkOutput("drain_gnt", 32'(gnt), 32'b0001);
      checkOutput("drain_tag", 32'(gnt_tag), 32'(i));
      checkOutput("drain_cnt", 32'(free_cnt), 32'(8 - i));
    end
    applyStimulus(4'b0001, 1'b0, 3'd0, 1'b0);
    checkOutput("empty_gnt", 32'(gnt), 32'd0);
    checkOutput("empty_flag", 32'(empty), 32'd1);
    checkOutput("empty_cnt", 32'(free_cnt), 32'd0);

    // Release into an empty pool is not grantable in the same cycle
    applyStimulus(4'b0001, 1'b1, 3'd5, 1'b0);
    checkOutput("relempty_gnt", 32'(gnt), 32'd0);
    applyStimulus(4'b0001, 1'b0, 3'd0, 1'b0);
    checkOutput("relempty_next_gnt", 32'(gnt), 32'b0001);
    checkOutput("relempty_next_tag", 32'(gnt_tag), 32'd5);
    checkOutput("relempty_next_cnt", 32'(free_cnt), 32'd1);
    applyStimulus(4'b0000, 1'b0, 3'd0, 1'b0);
    checkOutput("relempty_after_cnt", 32'(free_cnt), 32'd0);

    // Round-robin rotation with all requesters active
    applyReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b0, 3'd0, 1'b0);
      checkOutput("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
      checkOutput("rr_tag", 32'(gnt_tag), 32'(i));
    end

    // Grant and release together at free_cnt=3; released tag queues behind 5,6,7
    applyStimulus(4'b1111, 1'b1, 3'd2, 1'b0);
    checkOutput("both_cnt_before", 32'(free_cnt), 32'd3);
    checkOutput("both_gnt", 32'(gnt), 32'b0010);
    checkOutput("both_tag", 32'(gnt_tag), 32'd5);
    applyStimulus(4'b0000, 1'b0, 3'd0, 1'b0);
    checkOutput("both_cnt_after", 32'(free_cnt), 32'd3);
    applyStimulus(4'b1111, 1'b0, 3'd0, 1'b0);
    checkOutput("order_gnt0", 32'(gnt), 32'b0100);
    checkOutput("order_tag0", 32'(gnt_tag), 32'd6);
    applyStimulus(4'b1111, 1'b0, 3'd0, 1'b0);
    checkOutput("order_gnt1", 32'(gnt), 32'b1000);
    checkOutput("order_tag1", 32'(gnt_tag), 32'd7);
    applyStimulus(4'b1111, 1'b0, 3'd0, 1'b0);
    checkOutput("order_gnt2", 32'(gnt), 32'b0001);
    checkOutput("order_tag2", 32'(gnt_tag), 32'd2);
    checkOutput("order_cnt2", 32'(free_cnt), 32'd1);

    // Release into a full pool sets the sticky overflow flag and changes nothing else
    applyReset();
    applyStimulus(4'b0000, 1'b1, 3'd3, 1'b0);
    checkOutput("ovf_err_same", 32'(err_overflow), 32'd0);
    applyStimulus(4'b0000, 1'b0, 3'd0, 1'b0);
    checkOutput("ovf_err_set", 32'(err_overflow), 32'd1);
    checkOutput("ovf_cnt", 32'(free_cnt), 32'd8);
    applyStimulus(4'b0001, 1'b0, 3'd0, 1'b0);
    checkOutput("ovf_err_sticky", 32'(err_overflow), 32'd1);
    checkOutput("ovf_tag", 32'(gnt_tag), 32'd0);

    // Allocate 5 tags, then flush; releases during refill are ignored
    applyReset();
    checkOutput("reset_clears_err", 32'(err_overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0001, 1'b0, 3'd0, 1'b0);
    end
    applyStimulus(4'b1111, 1'b0, 3'd0, 1'b1);
    checkOutput("flush_gnt", 32'(gnt), 32'd0);
    checkOutput("flush_busy_same", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, (i == 3), 3'd6, 1'b0);
      checkOutput("refill_busy", 32'(busy), 32'd1);
      checkOutput("refill_gnt", 32'(gnt), 32'd0);
      checkOutput("refill_cnt", 32'(free_cnt), 32'd0);
    end
    applyStimulus(4'b1111, 1'b0, 3'd0, 1'b0);
    checkOutput("post_refill_busy", 32'(busy), 32'd0);
    checkOutput("post_refill_cnt", 32'(free_cnt), 32'd8);
    checkOutput("post_refill_gnt", 32'(gnt), 32'b0010);
    checkOutput("post_refill_tag", 32'(gnt_tag), 32'd0);
    checkOutput("post_refill_err", 32'(err_overflow), 32'd0);

    // Second flush at refill idx=4 restarts the 8-cycle refill
    applyStimulus(4'b0000, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b0, 3'd0, 1'b0);
      checkOutput("refill2_busy_pre", 32'(busy), 32'd1);
    end
    applyStimulus(4'b1111, 1'b0, 3'd0, 1'b1);
    checkOutput("reflush_busy", 32'(busy), 32'd1);
    checkOutput("reflush_gnt", 32'(gnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, 1'b0, 3'd0, 1'b0);
      checkOutput("refill2_busy", 32'(busy), 32'd1);
    end
    applyStimulus(4'b1111, 1'b0, 3'd0, 1'b0);
    checkOutput("post_refill2_busy", 32'(busy), 32'd0);
    checkOutput("post_refill2_cnt", 32'(free_cnt), 32'd8);
    checkOutput("post_refill2_gnt", 32'(gnt), 32'b0100);
    checkOutput("post_refill2_tag", 32'(gnt_tag), 32'd0);

    applyStimulus(4'b0000, 1'b0, 3'd0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
